// File: rtl/hamming_pkg.sv
//------------------------------------------------------------------------------
// Module      : hamming_pkg
// Description : Shared helpers for the SECDED stream codec. Provides parity-count
//               sizing, codeword position mapping and the decode status type.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hamming_pkg;

  // Smallest P with 2^P >= data_w + P + 1 (Hamming bound, plus the overall parity bit)
  function automatic int calc_p(input int data_w);
    int p;
    p = 1;
    while ((1 << p) < (data_w + p + 1)) begin
      p = p + 1;
    end
    return p;
  endfunction

  // Parity bits live at power-of-two positions
  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Data index carried at Hamming position pos, or -1 for a parity position
  function automatic int pos_to_data_idx(input int pos);
    int idx;
    idx = -1;
    if ((pos > 0) && !is_pow2(pos)) begin
      idx = 0;
      for (int i = 1; i < pos; i++) begin
        if (!is_pow2(i)) idx = idx + 1;
      end
    end
    return idx;
  endfunction

  typedef enum logic [1:0] {
    ST_CLEAN         = 2'd0,
    ST_CORRECTED     = 2'd1,
    ST_UNCORRECTABLE = 2'd2
  } dec_status_t;

endpackage

`default_nettype wire

// File: rtl/hamming_secded_dec.sv
//------------------------------------------------------------------------------
// Module      : hamming_secded_dec
// Description : Combinational SECDED decode: syndrome, overall parity, single-bit
//               correction and data extraction from an extended Hamming codeword.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hamming_secded_dec
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  localparam int P = calc_p(DATA_W),
  localparam int CODE_W = DATA_W + P + 1
) (
  input  logic [CODE_W-1:0] code,
  output logic [DATA_W-1:0] data,
  output logic [P-1:0]      syndrome,
  output dec_status_t       status
);

  logic [P-1:0] w_syn;
  logic         w_op;
  logic         w_in_range;

  // Syndrome is the XOR of the indices of every set Hamming position
  always_comb begin
    w_syn = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (code[i]) w_syn = w_syn ^ P'(i);
    end
  end

  assign w_op       = ^code;
  assign w_in_range = (w_syn != '0) && (int'(w_syn) <= (CODE_W - 1));
  assign syndrome   = w_syn;

  // Only an odd-parity word with an in-range syndrome gets a bit flipped
  for (genvar gp = 1; gp < CODE_W; gp++) begin : g_extract
    if (!is_pow2(gp)) begin : g_dat
      localparam int DIDX = pos_to_data_idx(gp);
      assign data[DIDX] = code[gp] ^ (w_op && (w_syn == P'(gp)));
    end
  end

  // Classify: clean, single (incl. overall parity bit) or uncorrectable
  always_comb begin
    status = ST_UNCORRECTABLE;
    if (!w_op && (w_syn == '0)) begin
      status = ST_CLEAN;
    end else if (w_op && ((w_syn == '0) || w_in_range)) begin
      status = ST_CORRECTED;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hamming_secded_stream.sv
//------------------------------------------------------------------------------
// Module      : hamming_secded_stream
// Description : Two-stage valid/ready SECDED codec. Stage 1 encodes (and may
//               corrupt) the input word, stage 2 decodes and registers results.
//               Saturating counters track corrected/uncorrectable words.
//               Optional macro HAMMING_ERR_INJECT_EN adds the inj_mask port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hamming_secded_stream
  import hamming_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16,
  localparam int P      = calc_p(DATA_W),
  localparam int CODE_W = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CODE_W-1:0] out_code,
  output logic [P-1:0]      out_syndrome,
  output logic              out_corrected,
  output logic              out_uncorrectable,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_corrected,
  output logic [CNT_W-1:0]  cnt_uncorrectable
`ifdef HAMMING_ERR_INJECT_EN
  ,
  input  logic [CODE_W-1:0] inj_mask
`endif
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic              w_advance;
  logic              w_out_hs;
  logic [CODE_W-1:0] w_mask;
  logic [CODE_W-1:0] w_spread;
  logic [P-1:0]      w_enc_syn;
  logic [CODE_W-1:0] w_enc;
  logic [DATA_W-1:0] w_dec_data;
  logic [P-1:0]      w_dec_syn;
  dec_status_t       w_dec_status;

  logic              r_s1_valid;
  logic [CODE_W-1:0] r_s1_code;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CODE_W-1:0] r_out_code;
  logic [P-1:0]      r_out_syn;
  logic              r_out_corr;
  logic              r_out_unc;
  logic [CNT_W-1:0]  r_cnt_corr;
  logic [CNT_W-1:0]  r_cnt_unc;

`ifdef HAMMING_ERR_INJECT_EN
  assign w_mask = inj_mask;
`else
  assign w_mask = '0;
`endif

  // Whole pipeline moves together; it only stalls when a held result is refused
  assign w_advance = ~r_out_valid | out_ready;
  assign w_out_hs  = r_out_valid & out_ready;
  assign in_ready  = w_advance;

  // Place data bits at the non-power-of-two positions, parity slots left at 0
  assign w_spread[0] = 1'b0;
  for (genvar gp = 1; gp < CODE_W; gp++) begin : g_enc_pos
    if (is_pow2(gp)) begin : g_par
      assign w_spread[gp] = 1'b0;
    end else begin : g_dat
      localparam int DIDX = pos_to_data_idx(gp);
      assign w_spread[gp] = in_data[DIDX];
    end
  end

  // Syndrome of the data-only word gives the parity bits directly
  always_comb begin
    w_enc_syn = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (w_spread[i]) w_enc_syn = w_enc_syn ^ P'(i);
    end
  end

  // Drop parity bits into place, then make the full codeword even parity
  always_comb begin
    w_enc = w_spread;
    for (int k = 0; k < P; k++) begin
      w_enc[1 << k] = w_enc_syn[k];
    end
    w_enc[0] = ^w_enc[CODE_W-1:1];
  end

  // Stage 1 register: encoded (and possibly corrupted) codeword
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      if (in_valid) r_s1_code <= w_enc ^ w_mask;
    end
  end

  hamming_secded_dec #(
    .DATA_W (DATA_W)
  ) u_dec (
    .code     (r_s1_code),
    .data     (w_dec_data),
    .syndrome (w_dec_syn),
    .status   (w_dec_status)
  );

  // Stage 2 register: decode results presented on out_*
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_code  <= '0;
      r_out_syn   <= '0;
      r_out_corr  <= 1'b0;
      r_out_unc   <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_dec_data;
        r_out_code <= r_s1_code;
        r_out_syn  <= w_dec_syn;
        r_out_corr <= (w_dec_status == ST_CORRECTED);
        r_out_unc  <= (w_dec_status == ST_UNCORRECTABLE);
      end
    end
  end

  // Saturating event counters; clear takes priority over an increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_corr <= '0;
      r_cnt_unc  <= '0;
    end else if (cnt_clr) begin
      r_cnt_corr <= '0;
      r_cnt_unc  <= '0;
    end else begin
      if (w_out_hs && r_out_corr && (r_cnt_corr != c_cnt_max)) r_cnt_corr <= r_cnt_corr + 1'b1;
      if (w_out_hs && r_out_unc && (r_cnt_unc != c_cnt_max))   r_cnt_unc  <= r_cnt_unc + 1'b1;
    end
  end

  assign out_valid         = r_out_valid;
  assign out_data          = r_out_data;
  assign out_code          = r_out_code;
  assign out_syndrome      = r_out_syn;
  assign out_corrected     = r_out_corr;
  assign out_uncorrectable = r_out_unc;
  assign cnt_corrected     = r_cnt_corr;
  assign cnt_uncorrectable = r_cnt_unc;

endmodule

`default_nettype wire

// File: tb/tb_hamming_secded_stream.sv
//------------------------------------------------------------------------------
// Module      : tb_hamming_secded_stream
// Description : Self-checking bench for hamming_secded_stream and its decoder.
//               Injection scenarios are exercised when HAMMING_ERR_INJECT_EN
//               is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hamming_secded_stream;
  import hamming_pkg::*;

  localparam int DW   = 4;
  localparam int CNTW = 2;
  localparam int CMAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, cnt_clr;
  logic [3:0]  in_data, out_data;
  logic [7:0]  out_code, inj_mask;
  logic [2:0]  out_syndrome;
  logic        out_corrected, out_uncorrectable;
  logic [1:0]  cnt_corrected, cnt_uncorrectable;

  logic [7:0]  dec4_code;
  logic [3:0]  dec4_data;
  logic [2:0]  dec4_syn;
  dec_status_t dec4_status;
  logic [71:0] dec64_code;
  logic [63:0] dec64_data;
  logic [6:0]  dec64_syn;
  dec_status_t dec64_status;

  int checks = 0;
  int failures = 0;
  int m_cnt_c = 0;
  int m_cnt_u = 0;
  logic [127:0] sb[$];
  bit          prev_stall = 1'b0;
  logic [7:0]  saved_code;

  always #5 clk = ~clk;

  hamming_secded_stream #(.DATA_W(DW), .CNT_W(CNTW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_code(out_code), .out_syndrome(out_syndrome),
    .out_corrected(out_corrected), .out_uncorrectable(out_uncorrectable),
    .cnt_clr(cnt_clr), .cnt_corrected(cnt_corrected),
    .cnt_uncorrectable(cnt_uncorrectable)
`ifdef HAMMING_ERR_INJECT_EN
    , .inj_mask(inj_mask)
`endif
  );

  hamming_secded_dec #(.DATA_W(4)) u_dec4 (
    .code(dec4_code), .data(dec4_data), .syndrome(dec4_syn), .status(dec4_status));
  hamming_secded_dec #(.DATA_W(64)) u_dec64 (
    .code(dec64_code), .data(dec64_data), .syndrome(dec64_syn), .status(dec64_status));

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model (straight from the code definition) ----------------
  function automatic int ref_p(input int dw);
    int p = 1;
    while ((2 ** p) < dw + p + 1) p++;
    return p;
  endfunction

  function automatic logic [127:0] ref_encode(input logic [63:0] d, input int dw);
    logic [127:0] c = '0;
    int cw = dw + ref_p(dw) + 1;
    int j = 0;
    bit par;
    for (int pos = 1; pos < cw; pos++)
      if ((pos & (pos - 1)) != 0) begin c[pos] = d[j]; j++; end
    for (int pos = 1; pos < cw; pos++)
      if ((pos & (pos - 1)) == 0) begin
        par = 1'b0;
        for (int q = 1; q < cw; q++) if ((q & pos) != 0) par ^= c[q];
        c[pos] = par;
      end
    c[0] = ^c;
    return c;
  endfunction

  function automatic void ref_decode(input logic [127:0] c, input int dw,
                                     output logic [63:0] d, output int s,
                                     output logic corr, output logic unc);
    int cw = dw + ref_p(dw) + 1;
    int j = 0;
    logic [127:0] cc = c;
    logic op = ^c;
    s = 0; corr = 1'b0; unc = 1'b0; d = '0;
    for (int pos = 1; pos < cw; pos++) if (c[pos]) s ^= pos;
    if (!op && s == 0) begin end
    else if (op && s == 0) corr = 1'b1;
    else if (op && s <= cw - 1) begin cc[s] = ~cc[s]; corr = 1'b1; end
    else unc = 1'b1;
    for (int pos = 1; pos < cw; pos++)
      if ((pos & (pos - 1)) != 0) begin d[j] = cc[pos]; j++; end
  endfunction

  // ---------------- standalone decoder checks ----------------
  task automatic dec_tests();
    logic [127:0] c, err;
    logic [63:0]  d, ed;
    int           es;
    logic         ec, eu;
    for (int t = 0; t < 120; t++) begin
      d = 64'($urandom_range(15));
      c = ref_encode(d, 4);
      err = '0;
      for (int e = 0; e < int'($urandom_range(3)); e++) err[$urandom_range(7)] ^= 1'b1;
      dec4_code = c[7:0] ^ err[7:0];
      #1;
      ref_decode(c ^ err, 4, ed, es, ec, eu);
      check_eq("dec4_data", dec4_data, ed);
      check_eq("dec4_syn", dec4_syn, es);
      check_eq("dec4_corr", dec4_status == ST_CORRECTED, ec);
      check_eq("dec4_unc", dec4_status == ST_UNCORRECTABLE, eu);
    end
    d = {$urandom, $urandom};
    c = ref_encode(d, 64);
    for (int pos = 0; pos < 72; pos++) begin
      err = '0; err[pos] = 1'b1;
      dec64_code = c[71:0] ^ err[71:0];
      #1;
      check_eq("dec64_sweep_data", dec64_data, d);
      check_eq("dec64_sweep_syn", dec64_syn, pos);
      check_eq("dec64_sweep_corr", dec64_status == ST_CORRECTED, 1);
    end
    for (int t = 0; t < 60; t++) begin
      d = {$urandom, $urandom};
      c = ref_encode(d, 64);
      err = '0;
      for (int e = 0; e < 2 + (t % 2); e++) err[$urandom_range(71)] ^= 1'b1;
      dec64_code = c[71:0] ^ err[71:0];
      #1;
      ref_decode(c ^ err, 64, ed, es, ec, eu);
      check_eq("dec64_data", dec64_data, ed);
      check_eq("dec64_syn", dec64_syn, es);
      check_eq("dec64_corr", dec64_status == ST_CORRECTED, ec);
      check_eq("dec64_unc", dec64_status == ST_UNCORRECTABLE, eu);
    end
  endtask

  // ---------------- directed single word with latency check ----------------
  task automatic send_one(input logic [3:0] d, input logic [7:0] mask, input bit clr,
                          input logic [7:0] e_code, input logic [3:0] e_data,
                          input int e_syn, input bit e_c, input bit e_u,
                          input int e_cc, input int e_cu);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; inj_mask = mask; out_ready = 1'b1; cnt_clr = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; inj_mask = '0;
    check_eq("lat_n1_valid", out_valid, 0);
    @(posedge clk); #1;
    check_eq("lat_n2_valid", out_valid, 1);
    check_eq("dir_code", out_code, e_code);
    check_eq("dir_data", out_data, e_data);
    check_eq("dir_syn", out_syndrome, e_syn);
    check_eq("dir_corr", out_corrected, e_c);
    check_eq("dir_unc", out_uncorrectable, e_u);
    cnt_clr = clr;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check_eq("dir_cnt_c", cnt_corrected, e_cc);
    check_eq("dir_cnt_u", cnt_uncorrectable, e_cu);
  endtask

  // ---------------- one cycle of streaming against the scoreboard ----------------
  task automatic cycle_step(input bit rnd);
    logic [127:0] exp_c;
    logic [63:0]  ed;
    int           es;
    logic         ec, eu;
    logic [31:0]  r;
    bit           hs;
    @(negedge clk);
    if (rnd) begin
      in_valid = ($urandom_range(3) != 0);
      r = $urandom; in_data = r[3:0];
      out_ready = ($urandom_range(4) < 3);
      cnt_clr = ($urandom_range(24) == 0);
`ifdef HAMMING_ERR_INJECT_EN
      case ($urandom_range(3))
        0: inj_mask = '0;
        1: begin inj_mask = '0; inj_mask[$urandom_range(7)] = 1'b1; end
        2: begin inj_mask = '0; inj_mask[$urandom_range(7)] ^= 1'b1; inj_mask[$urandom_range(7)] ^= 1'b1; end
        default: inj_mask = r[15:8];
      endcase
`endif
    end else begin
      in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0; inj_mask = '0;
    end
    #1;
    check_eq("cnt_c", cnt_corrected, m_cnt_c);
    check_eq("cnt_u", cnt_uncorrectable, m_cnt_u);
    if (prev_stall) check_eq("stall_stable", out_code, saved_code);
    hs = out_valid && out_ready;
    ec = 1'b0; eu = 1'b0;
    if (out_valid) begin
      if (sb.size() == 0) check_eq("spurious_valid", out_valid, 0);
      else begin
        exp_c = sb[0];
        ref_decode(exp_c, DW, ed, es, ec, eu);
        check_eq("st_code", out_code, exp_c);
        check_eq("st_data", out_data, ed);
        check_eq("st_syn", out_syndrome, es);
        check_eq("st_corr", out_corrected, ec);
        check_eq("st_unc", out_uncorrectable, eu);
        if (hs) void'(sb.pop_front());
      end
    end
    if (in_valid && in_ready) begin
`ifdef HAMMING_ERR_INJECT_EN
      sb.push_back(ref_encode(64'(in_data), DW) ^ 128'(inj_mask));
`else
      sb.push_back(ref_encode(64'(in_data), DW));
`endif
    end
    if (cnt_clr) begin m_cnt_c = 0; m_cnt_u = 0; end
    else begin
      if (hs && ec && m_cnt_c < CMAX) m_cnt_c++;
      if (hs && eu && m_cnt_u < CMAX) m_cnt_u++;
    end
    prev_stall = out_valid && !out_ready;
    saved_code = out_code;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cnt_clr = 1'b0;
    inj_mask = '0; dec4_code = '0; dec64_code = '0;

    dec_tests();

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_code", out_code, 0);
    check_eq("rst_data", out_data, 0);
    check_eq("rst_cnt_c", cnt_corrected, 0);
    check_eq("rst_cnt_u", cnt_uncorrectable, 0);
    rst = 1'b0;
    #1 check_eq("rst_in_ready", in_ready, 1);

    send_one(4'b1011, 8'h00, 1'b0, 8'hAA, 4'b1011, 0, 0, 0, 0, 0);
    send_one(4'b1111, 8'h00, 1'b0, 8'hFF, 4'b1111, 0, 0, 0, 0, 0);
    send_one(4'b0000, 8'h00, 1'b0, 8'h00, 4'b0000, 0, 0, 0, 0, 0);
`ifdef HAMMING_ERR_INJECT_EN
    send_one(4'b1011, 8'h20, 1'b0, 8'h8A, 4'b1011, 5, 1, 0, 1, 0);
    send_one(4'b1011, 8'h01, 1'b0, 8'hAB, 4'b1011, 0, 1, 0, 2, 0);
    send_one(4'b1011, 8'h06, 1'b0, 8'hAC, 4'b1011, 3, 0, 1, 2, 1);
    send_one(4'b1011, 8'h20, 1'b0, 8'h8A, 4'b1011, 5, 1, 0, 3, 1);
    send_one(4'b1011, 8'h20, 1'b0, 8'h8A, 4'b1011, 5, 1, 0, 3, 1);
    send_one(4'b1011, 8'h20, 1'b0, 8'h8A, 4'b1011, 5, 1, 0, 3, 1);
    send_one(4'b1011, 8'h20, 1'b1, 8'h8A, 4'b1011, 5, 1, 0, 0, 0);
`endif
    m_cnt_c = 0; m_cnt_u = 0;

    repeat (1500) cycle_step(1'b1);

    // Two words in flight, then an asynchronous reset between clock edges
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; cnt_clr = 1'b0; inj_mask = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_valid", out_valid, 0);
    check_eq("midrst_cnt_c", cnt_corrected, 0);
    check_eq("midrst_cnt_u", cnt_uncorrectable, 0);
    check_eq("midrst_code", out_code, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 check_eq("midrst_in_ready", in_ready, 1);
    sb.delete(); m_cnt_c = 0; m_cnt_u = 0; prev_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check_eq("post_rst_no_stale", out_valid, 0);
    end

    repeat (400) cycle_step(1'b1);
    repeat (20) cycle_step(1'b0);
    check_eq("drain_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hamming_secded_stream.md
# hamming_secded_stream

Parametrised, pipelined Hamming SECDED (single-error-correct, double-error-detect) codec. It encodes a DATA_W-bit word into an extended Hamming codeword, then decodes it through a valid/ready stream. It reports the syndrome, corrected/uncorrectable flags and saturating error counters. It is the next-generation replacement for the fixed 4-bit, correct-only encoder/decoder top level and sits in the same datapath position between the data source and the registered result outputs.

## Interface
- DATA_W, default 4: data width, 4..64.
- CNT_W, default 16: width of each error counter.
- Derived (not overridable): P = smallest integer with 2^P >= DATA_W+P+1; CODE_W = DATA_W+P+1.
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block accepts the input word this cycle.
- in_data  input  DATA_W  data to encode.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  DATA_W  decoded, corrected data.
- out_code  output  CODE_W  codeword as decoded, after any injection.
- out_syndrome  output  P  Hamming syndrome.
- out_corrected  output  1  single error corrected.
- out_uncorrectable  output  1  double or invalid error detected.
- cnt_clr  input  1  synchronous clear of both counters.
- cnt_corrected  output  CNT_W  count of corrected words.
- cnt_uncorrectable  output  CNT_W  count of uncorrectable words.
- inj_mask  input  CODE_W  error-injection XOR mask. Present only with HAMMING_ERR_INJECT_EN.

## Operation
- Codeword layout:
  - code[0] is the overall parity.
  - code[i], for i = 1..CODE_W-1, is Hamming position i.
  - Parity bit p_k sits at position 2^k.
  - Data bits fill the remaining positions in ascending order, in_data[0] first.
- Encoding:
  - p_k is the XOR of all data positions whose index has bit k set.
  - code[0] is the XOR of code[CODE_W-1:1], so the whole codeword has even parity.
- Stage 1 (encode): on accept, register code = encode(in_data) ^ inj_mask.
- Stage 2 (decode), using the registered codeword:
  - s = XOR of the indices of all set positions 1..CODE_W-1.
  - op = XOR of all CODE_W bits.
- Decode outcome cases:
  - s=0, op=0: clean. Data is passed through; both flags are 0.
  - op=1, s=0: the overall parity bit is in error. Data is unchanged; corrected=1.
  - op=1, 1 <= s <= CODE_W-1: flip position s, then extract the data; corrected=1.
  - op=1, s > CODE_W-1: uncorrectable=1; data is extracted uncorrected.
  - op=0, s != 0: double error. uncorrectable=1; data is extracted uncorrected.
- out_syndrome = s in every case.
- Counters:
  - Each counter increments on an output handshake (out_valid & out_ready) when its matching flag is set.
  - Counters saturate at 2^CNT_W-1.
  - If cnt_clr and an increment occur in the same cycle, the counter becomes 0 (clear wins).

## Timing
- Two-register pipeline. A word accepted in cycle N is presented on out_* from cycle N+2 when there is no stall.
- Global advance = ~out_valid | out_ready; in_ready = advance (combinational).
- While out_valid=1 and out_ready=0:
  - All stages hold.
  - out_* stay stable.
  - in_ready=0.
- The pipeline has no bubbles: back-to-back accepts with out_ready held high give one result per cycle.
- Reset (asynchronous, any time, including mid-stream):
  - Both stage-valid bits clear.
  - out_valid=0.
  - All out_* data and flags, and both counters, reset to 0.
  - In-flight words are discarded.
  - in_ready is 1 the first cycle after reset deasserts.
- in_data is sampled only when in_valid & in_ready.

## Configuration
- HAMMING_ERR_INJECT_EN defined: the inj_mask port exists and is applied at stage 1 as described.
- HAMMING_ERR_INJECT_EN undefined: the inj_mask port is absent and the mask is constant 0. The flags can then assert only in response to upsets of the internal registers.

## Structure
- The package hamming_pkg holds:
  - The function computing P from DATA_W.
  - An is_pow2 helper.
  - The position-to-data-index mapping function.
  - A typedef for the decode status {clean, corrected, uncorrectable}.
- The natural sub-module is hamming_secded_dec, the combinational syndrome, correction and data extraction logic. The top level owns the pipeline registers, handshake and counters.

## Test plan
- DATA_W=4, in_data=4'b1011, inj_mask=0 -> out_code=8'hAA, out_data=4'b1011, syndrome=0, both flags 0, at cycle N+2.
- inj_mask=8'h20 on 4'b1011 -> syndrome=5, corrected=1, out_data=4'b1011, cnt_corrected=1.
- inj_mask=8'h01 -> syndrome=0, corrected=1, out_data unchanged. inj_mask=8'h06 -> syndrome=3, uncorrectable=1, cnt_uncorrectable=1.
- Continuous in_valid with out_ready toggled randomly -> no word lost or duplicated, output order preserved, out_* stable while stalled.
- CNT_W=2, five single-error words -> cnt_corrected saturates at 3. Assert cnt_clr on the same cycle as an increment -> counter reads 0.
- Assert rst with two words in flight -> out_valid=0 and counters 0 immediately. No stale output after reset deasserts. DATA_W=64 (P=7, CODE_W=72) single-bit sweep across all 72 positions -> all corrected.
